// File: rtl/disp_pkg.sv
// Shared types and constants for the signed-decimal display decoder.
// Holds the FSM state encoding, segment constants and the BCD helpers.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_UPDATE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [2:0] LAST_ITER = 3'd7;

    // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit; other codes blank.
    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Double-dabble correction applied to a BCD nibble before each shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] n);
        logic [3:0] r;
        if (n >= 4'd5) begin
            r = n + 4'd3;
        end else begin
            r = n;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational 4-bit digit code to active-low seven-segment pattern.
module seg7_encode
    import disp_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    // Table lookup; non-decimal codes produce a blank digit.
    always_comb begin
        o_seg = digit_to_seg(i_code);
    end

endmodule

// File: rtl/twos_display_decoder.sv
// Captures an 8-bit two's-complement value, converts it to sign + BCD magnitude
// with a sequential double-dabble, and scans it onto a 4-digit 7-segment display.
module twos_display_decoder
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic       clk,
    input  logic       btnC,
    input  logic       btnU,
    input  logic [7:0] sw,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp,
    output logic       busy,
    output logic       neg
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(REFRESH_DIV - 1);

    state_t      r_state;
    logic        r_btnU_prev;
    logic [19:0] r_work;
    logic [2:0]  r_count;
    logic        r_sign;
    logic        r_nonzero;
    logic [3:0]  r_h;
    logic [3:0]  r_t;
    logic [3:0]  r_o;
    logic        r_neg;
    logic        r_busy;
    logic [CW-1:0] r_scan_cnt;
    logic [1:0]  r_idx;
    logic [6:0]  r_seg;
    logic [3:0]  r_an;

    logic        w_load;
    logic [7:0]  w_mag;
    logic [19:0] w_adj;
    logic [3:0]  w_code;
    logic [6:0]  w_enc;
    logic [6:0]  w_seg_next;

    // Rising edge of the load request, only honoured while idle.
    always_comb begin
        w_load = btnU & ~r_btnU_prev & (r_state == ST_IDLE);
    end

    // Magnitude of the switch value; 8'h80 maps to 128 as unsigned.
    always_comb begin
        if (sw[7]) begin
            w_mag = ~sw + 8'd1;
        end else begin
            w_mag = sw;
        end
    end

    // Work register layout {H,T,O,mag}: correct each BCD nibble ahead of the shift.
    always_comb begin
        w_adj        = r_work;
        w_adj[19:16] = dd_adjust(r_work[19:16]);
        w_adj[15:12] = dd_adjust(r_work[15:12]);
        w_adj[11:8]  = dd_adjust(r_work[11:8]);
    end

    // Load-edge history; cleared by reset so a held button after reset still loads.
    always_ff @(posedge clk) begin
        if (btnC) begin
            r_btnU_prev <= 1'b0;
        end else begin
            r_btnU_prev <= btnU;
        end
    end

    // Conversion FSM; shown digits only change in UPDATE so the display is double-buffered.
    always_ff @(posedge clk) begin
        if (btnC) begin
            r_state   <= ST_IDLE;
            r_work    <= 20'd0;
            r_count   <= 3'd0;
            r_sign    <= 1'b0;
            r_nonzero <= 1'b0;
            r_h       <= 4'd0;
            r_t       <= 4'd0;
            r_o       <= 4'd0;
            r_neg     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state   <= ST_CONVERT;
                        r_busy    <= 1'b1;
                        r_sign    <= sw[7];
                        r_nonzero <= (sw != 8'd0);
                        r_work    <= {12'd0, w_mag};
                        r_count   <= 3'd0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CONVERT: begin
                    r_work  <= w_adj << 1;
                    r_count <= r_count + 3'd1;
                    if (r_count == LAST_ITER) begin
                        r_state <= ST_UPDATE;
                    end else begin
                        r_state <= ST_CONVERT;
                    end
                end
                ST_UPDATE: begin
                    r_h     <= r_work[19:16];
                    r_t     <= r_work[15:12];
                    r_o     <= r_work[11:8];
                    r_neg   <= r_sign & r_nonzero;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Free-running scan timer; each wrap moves to the next digit position.
    always_ff @(posedge clk) begin
        if (btnC) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_idx      <= r_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + CW'(1);
        end
    end

    // Digit selection with leading-zero blanking.
    always_comb begin
        case (r_idx)
            2'd0:    w_code = r_o;
            2'd1:    w_code = ((r_h == 4'd0) && (r_t == 4'd0)) ? CODE_BLANK : r_t;
            2'd2:    w_code = (r_h == 4'd0) ? CODE_BLANK : r_h;
            default: w_code = CODE_BLANK;
        endcase
    end

    seg7_encode u_seg7_encode (
        .i_code (w_code),
        .o_seg  (w_enc)
    );

    // The leftmost position carries only the sign.
    always_comb begin
        if (r_idx == 2'd3) begin
            w_seg_next = r_neg ? SEG_MINUS : SEG_BLANK;
        end else begin
            w_seg_next = w_enc;
        end
    end

    // Registered display drive.
    always_ff @(posedge clk) begin
        if (btnC) begin
            r_seg <= SEG_BLANK;
            r_an  <= 4'hF;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= ~(4'b0001 << r_idx);
        end
    end

    assign seg  = r_seg;
    assign an   = r_an;
    assign dp   = 1'b1;
    assign busy = r_busy;
    assign neg  = r_neg;

endmodule

// File: tb/tb_twos_display_decoder.sv
// Randomised and directed checks of the signed display decoder against a
// decimal-arithmetic reference model.
module tb_twos_display_decoder;

    logic       clk;
    logic       btnC;
    logic       btnU;
    logic [7:0] sw;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       busy;
    logic       neg;

    int n_checks;
    int n_fail;
    logic [6:0] seen [4];

    twos_display_decoder #(.REFRESH_DIV(4)) dut (
        .clk  (clk),
        .btnC (btnC),
        .btnU (btnU),
        .sw   (sw),
        .seg  (seg),
        .an   (an),
        .dp   (dp),
        .busy (busy),
        .neg  (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_digit(input int d);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return tbl[d];
    endfunction

    // Expected {pos3,pos2,pos1,pos0} patterns computed from the signed value.
    function automatic logic [27:0] ref_display(input logic [7:0] v);
        int s, m, h, t, o;
        logic [6:0] p3, p2, p1, p0;
        s = (v >= 8'd128) ? int'(v) - 256 : int'(v);
        m = (s < 0) ? -s : s;
        h = m / 100;
        t = (m / 10) % 10;
        o = m % 10;
        p0 = ref_digit(o);
        p1 = (h == 0 && t == 0) ? 7'h7F : ref_digit(t);
        p2 = (h == 0) ? 7'h7F : ref_digit(h);
        p3 = (s < 0) ? 7'h3F : 7'h7F;
        return {p3, p2, p1, p0};
    endfunction

    function automatic logic ref_neg(input logic [7:0] v);
        return v[7];
    endfunction

    // Sample the scan for a few full rotations and compare each digit position.
    task automatic check_scan(input logic [7:0] v);
        logic [27:0] e;
        int bad_an;
        e = ref_display(v);
        bad_an = 0;
        for (int i = 0; i < 4; i++) seen[i] = 7'hxx;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            case (an)
                4'b1110: seen[0] = seg;
                4'b1101: seen[1] = seg;
                4'b1011: seen[2] = seg;
                4'b0111: seen[3] = seg;
                default: bad_an++;
            endcase
        end
        check_eq("an_onehot", 32'(bad_an), 32'd0);
        check_eq("digit0", {25'd0, seen[0]}, {25'd0, e[6:0]});
        check_eq("digit1", {25'd0, seen[1]}, {25'd0, e[13:7]});
        check_eq("digit2", {25'd0, seen[2]}, {25'd0, e[20:14]});
        check_eq("digit3", {25'd0, seen[3]}, {25'd0, e[27:21]});
        check_eq("dp", {31'd0, dp}, 32'd1);
    endtask

    // Single-cycle load pulse; checks the 9-cycle busy window and the sign flag.
    task automatic do_load(input logic [7:0] v);
        int cnt;
        @(negedge clk);
        sw   = v;
        btnU = 1'b1;
        @(negedge clk);
        btnU = 1'b0;
        check_eq("busy_k1", {31'd0, busy}, 32'd1);
        cnt = 1;
        @(negedge clk);
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check_eq("busy_len", 32'(cnt), 32'd9);
        check_eq("neg", {31'd0, neg}, {31'd0, ref_neg(v)});
    endtask

    initial begin
        int windows;
        logic prev_busy;
        logic [7:0] v;
        n_checks = 0;
        n_fail   = 0;
        btnC = 1'b1;
        btnU = 1'b0;
        sw   = 8'h00;

        // Reset state.
        repeat (2) @(negedge clk);
        check_eq("rst_seg", {25'd0, seg}, 32'h7F);
        check_eq("rst_an", {28'd0, an}, 32'hF);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_neg", {31'd0, neg}, 32'd0);
        btnC = 1'b0;
        @(negedge clk);
        check_eq("post_rst_an", {28'd0, an}, 32'hE);
        check_eq("post_rst_seg", {25'd0, seg}, 32'h40);

        // Directed values from the examples and boundaries.
        do_load(8'h05); check_scan(8'h05);
        do_load(8'h80); check_scan(8'h80);
        do_load(8'h9C); check_scan(8'h9C);
        do_load(8'h00); check_scan(8'h00);
        do_load(8'h7F); check_scan(8'h7F);
        do_load(8'hFF); check_scan(8'hFF);

        // Random values.
        for (int n = 0; n < 16; n++) begin
            v = 8'($urandom_range(255, 0));
            do_load(v);
            check_scan(v);
        end

        // Held button: exactly one busy window.
        @(negedge clk);
        sw = 8'hFF;
        btnU = 1'b1;
        windows = 0;
        prev_busy = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (busy && !prev_busy) windows++;
            prev_busy = busy;
        end
        btnU = 1'b0;
        check_eq("held_windows", 32'(windows), 32'd1);
        check_scan(8'hFF);

        // Second edge during busy is ignored.
        @(negedge clk);
        sw = 8'h05;
        btnU = 1'b1;
        @(negedge clk);
        btnU = 1'b0;
        @(negedge clk);
        sw = 8'h80;
        btnU = 1'b1;
        @(negedge clk);
        btnU = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("busy_ignore_done", {31'd0, busy}, 32'd0);
        check_eq("busy_ignore_neg", {31'd0, neg}, 32'd0);
        check_scan(8'h05);

        // Reset mid-conversion aborts and clears the display.
        do_load(8'h80);
        @(negedge clk);
        sw = 8'h63;
        btnU = 1'b1;
        @(negedge clk);
        btnU = 1'b0;
        repeat (3) @(negedge clk);
        btnC = 1'b1;
        @(negedge clk);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_neg", {31'd0, neg}, 32'd0);
        btnC = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("abort_idle", {31'd0, busy}, 32'd0);
        check_scan(8'h00);

        // Reset wins over a same-cycle load edge.
        @(negedge clk);
        sw = 8'h63;
        btnC = 1'b1;
        btnU = 1'b1;
        @(negedge clk);
        btnC = 1'b0;
        btnU = 1'b0;
        check_eq("rst_wins_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check_eq("rst_wins_busy2", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
